// File: rtl/dom_rnd_gen.sv
// Fresh-randomness source for DOM masked gates: L parallel 32-bit Fibonacci LFSR lanes,
// seeded word by word, warmed up, then stepped once per consumed output. Macro DOM_RND_RESEED_EN adds auto-reseed.
module dom_rnd_gen #(
  parameter int D        = 2,
  parameter int W        = 1,
  parameter int Z        = D * (D - 1) / 2,
  parameter int WARM     = 16,
  parameter int RESEED_N = 1024,
  localparam int RW      = W * Z,
  localparam int L       = (RW + 31) / 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [31:0]   seed_i,
  input  logic          seed_valid_i,
  output logic          seed_ready_o,
  input  logic          reseed_i,
  output logic [RW-1:0] rnd_o,
  output logic          rnd_valid_o,
  input  logic          rnd_ready_i,
  output logic          reseed_req_o
);

  localparam logic [1:0] ST_SEED = 2'd0;
  localparam logic [1:0] ST_WARM = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

  localparam int IDX_W = (L > 1) ? $clog2(L) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(L - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_ZERO = IDX_W'(0);
  localparam logic [7:0]       WARM_LAST = 8'(WARM - 1);

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
  endfunction

  function automatic logic [L-1:0][31:0] lfsr_step_all(input logic [L-1:0][31:0] v);
    logic [L-1:0][31:0] r;
    for (int i = 0; i < L; i++) begin
      r[i] = lfsr_step(v[i]);
    end
    return r;
  endfunction

  // An all-zero lane would lock the LFSR, so a zero seed word is promoted to 1.
  function automatic logic [31:0] seed_fix(input logic [31:0] s);
    return (s == 32'h0) ? 32'h1 : s;
  endfunction

  logic [1:0]         state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [7:0]         warm_q, warm_d;
  logic [L-1:0][31:0] lane_q, lane_d;
  logic               handshake_s;

  assign handshake_s = (state_q == ST_RUN) && rnd_ready_i;

`ifdef DOM_RND_RESEED_EN
  localparam int CNT_W = $clog2(RESEED_N + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RESEED_N - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             auto_reseed_s;

  assign auto_reseed_s = handshake_s && (cnt_q == CNT_LAST);

  // Output counter: cleared whenever the next state is SEED, else counts handshakes.
  always_comb begin
    if (state_d == ST_SEED) begin
      cnt_d = CNT_ZERO;
    end else if (handshake_s) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Output counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= CNT_ZERO;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic auto_reseed_s;
  assign auto_reseed_s = 1'b0;
`endif

  // Next-state logic for the SEED / WARM / RUN sequencer and the lanes.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    warm_d  = warm_q;
    lane_d  = lane_q;
    case (state_q)
      ST_SEED: begin
        warm_d = 8'd0;
        if (seed_valid_i) begin
          lane_d[idx_q] = seed_fix(seed_i);
          if (idx_q == IDX_LAST) begin
            state_d = ST_WARM;
            idx_d   = IDX_ZERO;
          end else begin
            idx_d = idx_q + IDX_ONE;
          end
        end else begin
          idx_d = idx_q;
        end
      end
      ST_WARM: begin
        lane_d = lfsr_step_all(lane_q);
        if (warm_q == WARM_LAST) begin
          state_d = ST_RUN;
          warm_d  = 8'd0;
        end else begin
          warm_d = warm_q + 8'd1;
        end
      end
      ST_RUN: begin
        // The step for a handshake still happens when the same cycle leaves RUN.
        if (handshake_s) begin
          lane_d = lfsr_step_all(lane_q);
        end else begin
          lane_d = lane_q;
        end
        if (reseed_i || auto_reseed_s) begin
          state_d = ST_SEED;
          idx_d   = IDX_ZERO;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_SEED;
        idx_d   = IDX_ZERO;
        warm_d  = 8'd0;
      end
    endcase
  end

  // State, index, warm counter and lane registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_SEED;
      idx_q   <= IDX_ZERO;
      warm_q  <= 8'd0;
      lane_q  <= {L{32'h1}};
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      warm_q  <= warm_d;
      lane_q  <= lane_d;
    end
  end

  assign seed_ready_o = (state_q == ST_SEED);
  assign reseed_req_o = (state_q == ST_SEED);
  assign rnd_valid_o  = (state_q == ST_RUN);
  assign rnd_o        = RW'(lane_q);

endmodule

// File: tb/tb_dom_rnd_gen.sv
// Bench for dom_rnd_gen: instance A (RW=32, L=1, WARM=1) and instance B (RW=40, L=2, WARM=16),
// a seed/step-count reference model, and directed stimulus with literal expectations.
module tb_dom_rnd_gen;

  localparam int PH_SEED = 0;
  localparam int PH_WARM = 1;
  localparam int PH_RUN  = 2;
  localparam int RN      = 4;
  localparam int ML [2]  = '{1, 2};
  localparam int MW [2]  = '{1, 16};

  logic        clk;
  logic        rst_n;
  logic [31:0] seed_s [2];
  logic        seed_valid_s [2];
  logic        reseed_s [2];
  logic        rnd_ready_s [2];
  logic        seed_ready_s [2];
  logic        rnd_valid_s [2];
  logic        reseed_req_s [2];
  logic [31:0] rnd_a;
  logic [39:0] rnd_b;
  logic [63:0] rnd_x [2];

  int n_cmp  = 0;
  int n_fail = 0;

  int          m_phase [2];
  logic [31:0] m_seed [2][2];
  int          m_idx [2];
  int          m_wleft [2];
  int          m_steps [2];
  int          m_hs [2];
  bit          m_fresh [2];

  assign rnd_x[0] = {32'h0, rnd_a};
  assign rnd_x[1] = {24'h0, rnd_b};

  dom_rnd_gen #(.D(2), .W(32), .WARM(1), .RESEED_N(RN)) dut_a (
    .clk(clk), .rst_n(rst_n), .seed_i(seed_s[0]), .seed_valid_i(seed_valid_s[0]),
    .seed_ready_o(seed_ready_s[0]), .reseed_i(reseed_s[0]), .rnd_o(rnd_a),
    .rnd_valid_o(rnd_valid_s[0]), .rnd_ready_i(rnd_ready_s[0]), .reseed_req_o(reseed_req_s[0])
  );

  dom_rnd_gen #(.D(2), .W(40), .WARM(16), .RESEED_N(RN)) dut_b (
    .clk(clk), .rst_n(rst_n), .seed_i(seed_s[1]), .seed_valid_i(seed_valid_s[1]),
    .seed_ready_o(seed_ready_s[1]), .reseed_i(reseed_s[1]), .rnd_o(rnd_b),
    .rnd_valid_o(rnd_valid_s[1]), .rnd_ready_i(rnd_ready_s[1]), .reseed_req_o(reseed_req_s[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] lfsr_n(input logic [31:0] s, input int n);
    logic [31:0] v;
    v = s;
    for (int k = 0; k < n; k++) begin
      v = {v[30:0], v[31] ^ v[21] ^ v[1] ^ v[0]};
    end
    return v;
  endfunction

  // Every lane is its seed advanced by the number of steps taken since seeding completed.
  function automatic logic [63:0] exp_rnd(input int j);
    logic [63:0] v;
    v = 64'h0;
    v[31:0] = lfsr_n(m_seed[j][0], m_steps[j]);
    if (ML[j] == 2) begin
      v[63:32] = lfsr_n(m_seed[j][1], m_steps[j]);
      v = v & 64'h0000_00FF_FFFF_FFFF;
    end
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reference model: advances at each clock edge from the inputs the DUTs see.
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      for (int j = 0; j < 2; j++) begin
        if (!rst_n) begin
          m_phase[j] = PH_SEED; m_seed[j][0] = 32'h1; m_seed[j][1] = 32'h1;
          m_idx[j] = 0; m_wleft[j] = 0; m_steps[j] = 0; m_hs[j] = 0; m_fresh[j] = 1'b1;
        end else if (m_phase[j] == PH_SEED) begin
          if (seed_valid_s[j]) begin
            m_seed[j][m_idx[j]] = (seed_s[j] == 32'h0) ? 32'h1 : seed_s[j];
            m_fresh[j] = 1'b0;
            if (m_idx[j] == ML[j] - 1) begin
              m_phase[j] = PH_WARM; m_idx[j] = 0; m_steps[j] = 0; m_wleft[j] = MW[j];
            end else begin
              m_idx[j]++;
            end
          end
        end else if (m_phase[j] == PH_WARM) begin
          m_steps[j]++;
          m_wleft[j]--;
          if (m_wleft[j] == 0) m_phase[j] = PH_RUN;
        end else begin
          if (rnd_ready_s[j]) begin
            m_steps[j]++;
            m_hs[j]++;
          end
          if (reseed_s[j]) begin
            m_phase[j] = PH_SEED; m_hs[j] = 0;
          end
`ifdef DOM_RND_RESEED_EN
          else if (m_hs[j] == RN) begin
            m_phase[j] = PH_SEED; m_hs[j] = 0;
          end
`endif
        end
      end
    end
  end

  // Compare process: flags every cycle, randomness whenever it is defined.
  initial begin
    forever begin
      @(negedge clk);
      for (int j = 0; j < 2; j++) begin
        chk($sformatf("valid[%0d]", j), 64'(rnd_valid_s[j]), 64'(m_phase[j] == PH_RUN));
        chk($sformatf("seed_ready[%0d]", j), 64'(seed_ready_s[j]), 64'(m_phase[j] == PH_SEED));
        chk($sformatf("reseed_req[%0d]", j), 64'(reseed_req_s[j]), 64'(m_phase[j] == PH_SEED));
        if (m_phase[j] == PH_RUN || m_fresh[j]) begin
          chk($sformatf("rnd[%0d]", j), rnd_x[j], exp_rnd(j));
        end
      end
    end
  end

  task automatic seed_a(input logic [31:0] s);
    seed_s[0] = s; seed_valid_s[0] = 1'b1; reseed_s[0] = 1'b1;
    cyc();
    seed_valid_s[0] = 1'b0;
    chk("a_warm_valid", 64'(rnd_valid_s[0]), 64'h0);
    cyc();
    reseed_s[0] = 1'b0;
  endtask

  task automatic hs_a();
    rnd_ready_s[0] = 1'b1;
    cyc();
    rnd_ready_s[0] = 1'b0;
  endtask

  task automatic seed_b(input logic [31:0] s0, input logic [31:0] s1);
    seed_s[1] = s0; seed_valid_s[1] = 1'b1;
    cyc();
    seed_s[1] = s1;
    cyc();
    seed_valid_s[1] = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    for (int j = 0; j < 2; j++) begin
      seed_s[j] = 32'h0; seed_valid_s[j] = 1'b0; reseed_s[j] = 1'b0; rnd_ready_s[j] = 1'b0;
    end
    repeat (3) cyc();
    chk("rst_valid_a", 64'(rnd_valid_s[0]), 64'h0);
    chk("rst_sready_a", 64'(seed_ready_s[0]), 64'h1);
    chk("rst_rreq_a", 64'(reseed_req_s[0]), 64'h1);
    chk("rst_rnd_a", 64'(rnd_a), 64'h1);
    chk("rst_rnd_b", 64'(rnd_b), 64'h01_0000_0001);
    rst_n = 1'b1;
    cyc();

    // Single-word seed of 1, reseed_i held high across SEED and WARM (ignored).
    seed_a(32'h1);
    chk("a_run_valid", 64'(rnd_valid_s[0]), 64'h1);
    chk("a_first_rnd", 64'(rnd_a), 64'h3);
    hs_a();
    chk("a_second_rnd", 64'(rnd_a), 64'h6);

    // Backpressure with a stray seed word that must be ignored in RUN.
    seed_s[0] = 32'hDEAD_BEEF; seed_valid_s[0] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("bp_rnd", 64'(rnd_a), 64'h6);
      chk("bp_valid", 64'(rnd_valid_s[0]), 64'h1);
    end
    seed_valid_s[0] = 1'b0;
    rnd_ready_s[0] = 1'b1;
    cyc();
    chk("stream_rnd1", 64'(rnd_a), 64'hD);
    cyc();
    chk("stream_rnd2", 64'(rnd_a), 64'h1B);

    // Reseed together with a handshake: the step still happens.
    reseed_s[0] = 1'b1;
    cyc();
    reseed_s[0] = 1'b0; rnd_ready_s[0] = 1'b0;
    chk("rs_rnd", 64'(rnd_a), 64'h36);
    chk("rs_valid", 64'(rnd_valid_s[0]), 64'h0);
    chk("rs_req", 64'(reseed_req_s[0]), 64'h1);

    // Zero seed behaves as seed 1.
    seed_a(32'h0);
    chk("z_first_rnd", 64'(rnd_a), 64'h3);
    hs_a();
    chk("z_second_rnd", 64'(rnd_a), 64'h6);
    hs_a();
    hs_a();
    chk("ar_3rd_valid", 64'(rnd_valid_s[0]), 64'h1);
    chk("ar_3rd_rnd", 64'(rnd_a), 64'h1B);
    hs_a();
    chk("ar_4th_rnd", 64'(rnd_a), 64'h36);
`ifdef DOM_RND_RESEED_EN
    chk("ar_4th_valid", 64'(rnd_valid_s[0]), 64'h0);
    chk("ar_4th_req", 64'(reseed_req_s[0]), 64'h1);
`else
    chk("ar_4th_valid", 64'(rnd_valid_s[0]), 64'h1);
    chk("ar_4th_req", 64'(reseed_req_s[0]), 64'h0);
`endif

    // Multi-lane seeding of B.
    seed_b(32'hA5A5_A5A5, 32'h0000_005A);
    chk("b_warm_sready", 64'(seed_ready_s[1]), 64'h0);
    repeat (15) cyc();
    chk("b_warm_end_valid", 64'(rnd_valid_s[1]), 64'h0);
    cyc();
    chk("b_run_valid", 64'(rnd_valid_s[1]), 64'h1);
    rnd_ready_s[1] = 1'b1;
    repeat (3) cyc();
    rnd_ready_s[1] = 1'b0;
    reseed_s[1] = 1'b1;
    cyc();
    reseed_s[1] = 1'b0;
    seed_b(32'h0, 32'h1234_5678);
    repeat (5) cyc();

    // Asynchronous reset in the middle of WARM.
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid_b", 64'(rnd_valid_s[1]), 64'h0);
    chk("mid_rst_sready_b", 64'(seed_ready_s[1]), 64'h1);
    chk("mid_rst_rnd_b", 64'(rnd_b), 64'h01_0000_0001);
    chk("mid_rst_rnd_a", 64'(rnd_a), 64'h1);
    repeat (2) cyc();
    rst_n = 1'b1;
    cyc();
    seed_b(32'hCAFE_F00D, 32'h0000_0033);
    repeat (16) cyc();
    chk("b_restart_valid", 64'(rnd_valid_s[1]), 64'h1);
    rnd_ready_s[1] = 1'b1;
    repeat (2) cyc();
    rnd_ready_s[1] = 1'b0;
    repeat (2) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
